// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Streams machine-code words into instruction memory from address 0
//             and sequences the CPU core's reset around load / run / halt.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int D = 12,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         loadStart,
    input  logic         inValid,
    input  logic [W-1:0] inData,
    input  logic         inLast,
    output logic         inReady,
    input  logic         cpuDone,
    output logic         wrEn,
    output logic [D-1:0] wrAddr,
    output logic [W-1:0] wrData,
    output logic         cpuReset,
    output logic [D:0]   loadCount,
    output logic         errOverflow,
    output logic [2:0]   state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_LOAD   = 3'b001,
        S_SETTLE = 3'b010,
        S_RUN    = 3'b011,
        S_HALT   = 3'b100
    } state_t;

    localparam logic [D:0] c_LAST_PTR = {1'b0, {D{1'b1}}};

    state_t         r_state;
    state_t         w_nextState;
    logic           r_wrEn;
    logic [D-1:0]   r_wrAddr;
    logic [W-1:0]   r_wrData;
    logic [D:0]     r_loadCount;
    logic           r_errOverflow;

    logic           w_transfer;
    logic           w_startLoad;
    logic           w_atLimit;

    // loadCount doubles as the write pointer; it never exceeds DEPTH.
    assign w_transfer  = inValid & (r_state == S_LOAD);
    assign w_startLoad = loadStart & ((r_state == S_IDLE) | (r_state == S_HALT));
    assign w_atLimit   = (r_loadCount == c_LAST_PTR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (loadStart) begin
                    w_nextState = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_transfer) begin
                    if (inLast) begin
                        w_nextState = S_SETTLE;
                    end else if (w_atLimit) begin
                        w_nextState = S_IDLE;
                    end
                end
            end
            S_SETTLE: w_nextState = S_RUN;
            S_RUN: begin
                if (cpuDone) begin
                    w_nextState = S_HALT;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrEn        <= 1'b0;
            r_wrAddr      <= '0;
            r_wrData      <= '0;
            r_loadCount   <= '0;
            r_errOverflow <= 1'b0;
        end else begin
            r_wrEn <= w_transfer;
            if (w_startLoad) begin
                r_loadCount   <= '0;
                r_errOverflow <= 1'b0;
            end
            if (w_transfer) begin
                r_wrAddr    <= r_loadCount[D-1:0];
                r_wrData    <= inData;
                r_loadCount <= r_loadCount + (D+1)'(1);
                if (!inLast && w_atLimit) begin
                    r_errOverflow <= 1'b1;
                end
            end
        end
    end

    assign inReady     = (r_state == S_LOAD);
    assign cpuReset    = (r_state != S_RUN);
    assign state       = r_state;
    assign wrEn        = r_wrEn;
    assign wrAddr      = r_wrAddr;
    assign wrData      = r_wrData;
    assign loadCount   = r_loadCount;
    assign errOverflow = r_errOverflow;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Self-checking bench: a full-size loader and a D=3 loader checked
//             against a behavioural model plus directed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;
    localparam int W = 9;
    localparam int M_IDLE = 0, M_LOAD = 1, M_SETTLE = 2, M_RUN = 3, M_HALT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        reset, loadStart, inValid, inLast, cpuDone;
    logic [1:0][W-1:0] inData;
    logic [1:0]        inReady, wrEn, cpuReset, errOverflow;
    logic [1:0][W-1:0] wrData;
    logic [1:0][2:0]   state;
    logic [11:0]       wrAddrA;
    logic [2:0]        wrAddrB;
    logic [12:0]       loadCountA;
    logic [3:0]        loadCountB;

    imem_loader #(.D(12), .W(W)) dutA (
        .clk(clk), .reset(reset[0]), .loadStart(loadStart[0]), .inValid(inValid[0]),
        .inData(inData[0]), .inLast(inLast[0]), .inReady(inReady[0]), .cpuDone(cpuDone[0]),
        .wrEn(wrEn[0]), .wrAddr(wrAddrA), .wrData(wrData[0]), .cpuReset(cpuReset[0]),
        .loadCount(loadCountA), .errOverflow(errOverflow[0]), .state(state[0])
    );

    imem_loader #(.D(3), .W(W)) dutB (
        .clk(clk), .reset(reset[1]), .loadStart(loadStart[1]), .inValid(inValid[1]),
        .inData(inData[1]), .inLast(inLast[1]), .inReady(inReady[1]), .cpuDone(cpuDone[1]),
        .wrEn(wrEn[1]), .wrAddr(wrAddrB), .wrData(wrData[1]), .cpuReset(cpuReset[1]),
        .loadCount(loadCountB), .errOverflow(errOverflow[1]), .state(state[1])
    );

    int asserts = 0;
    int failures = 0;
    bit checkOn = 0;

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Behavioural model: mode, accepted-word pointer and the pending write.
    int depth [2] = '{4096, 8};
    int mMode [2];
    int mPtr  [2];
    int mAddr [2];
    int mData [2];
    bit mOvf  [2];
    bit mPulse[2];

    always @(posedge clk) begin : model
        for (int k = 0; k < 2; k++) begin
            if (reset[k]) begin
                mMode[k] = M_IDLE; mPtr[k] = 0; mOvf[k] = 0; mPulse[k] = 0;
            end else begin
                mPulse[k] = 0;
                case (mMode[k])
                    M_IDLE, M_HALT: if (loadStart[k]) begin
                        mMode[k] = M_LOAD; mPtr[k] = 0; mOvf[k] = 0;
                    end
                    M_LOAD: if (inValid[k]) begin
                        mPulse[k] = 1; mAddr[k] = mPtr[k]; mData[k] = int'(inData[k]);
                        mPtr[k]++;
                        if (inLast[k]) mMode[k] = M_SETTLE;
                        else if (mPtr[k] == depth[k]) begin
                            mOvf[k] = 1; mMode[k] = M_IDLE;
                        end
                    end
                    M_SETTLE: mMode[k] = M_RUN;
                    M_RUN: if (cpuDone[k]) mMode[k] = M_HALT;
                    default: mMode[k] = M_IDLE;
                endcase
            end
        end
    end

    logic [20:0] wlog0[$];
    logic [20:0] wlog1[$];

    always @(negedge clk) begin : compare
        logic [11:0] a;
        logic [12:0] c;
        if (checkOn) begin
            for (int k = 0; k < 2; k++) begin
                a = (k == 0) ? wrAddrA : {9'd0, wrAddrB};
                c = (k == 0) ? loadCountA : {9'd0, loadCountB};
                chk("state", k, 32'(state[k]), 32'(mMode[k]));
                chk("inReady", k, 32'(inReady[k]), 32'(mMode[k] == M_LOAD));
                chk("cpuReset", k, 32'(cpuReset[k]), 32'(mMode[k] != M_RUN));
                chk("wrEn", k, 32'(wrEn[k]), 32'(mPulse[k]));
                chk("loadCount", k, 32'(c), 32'(mPtr[k]));
                chk("errOverflow", k, 32'(errOverflow[k]), 32'(mOvf[k]));
                if (mPulse[k]) begin
                    chk("wrAddr", k, 32'(a), 32'(mAddr[k]));
                    chk("wrData", k, 32'(wrData[k]), 32'(mData[k]));
                end
                if (wrEn[k] === 1'b1) begin
                    if (k == 0) wlog0.push_back({a, wrData[k]});
                    else        wlog1.push_back({a, wrData[k]});
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendWord(int k, logic [W-1:0] d, logic last);
        inValid[k] = 1'b1; inData[k] = d; inLast[k] = last;
        tick();
        inValid[k] = 1'b0; inLast[k] = 1'b0;
    endtask

    task automatic startLoad(int k);
        loadStart[k] = 1'b1;
        tick();
        loadStart[k] = 1'b0;
    endtask

    task automatic checkWrites(string name, int k, logic [20:0] exp[$]);
        logic [20:0] got[$];
        got = (k == 0) ? wlog0 : wlog1;
        chk({name, "_count"}, k, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk({name, "_entry"}, k, 32'(got[i]), 32'(exp[i]));
        if (k == 0) wlog0.delete(); else wlog1.delete();
    endtask

    initial begin
        logic [20:0] exp[$];
        reset = 2'b11; loadStart = '0; inValid = '0; inLast = '0; cpuDone = '0; inData = '0;

        // 1: reset state
        tick();
        checkOn = 1;
        tick();
        chk("t1_state", 0, 32'(state[0]), 32'h0);
        chk("t1_cpuReset", 0, 32'(cpuReset[0]), 32'h1);
        chk("t1_inReady", 0, 32'(inReady[0]), 32'h0);
        chk("t1_wrEn", 0, 32'(wrEn[0]), 32'h0);
        chk("t1_loadCount", 0, 32'(loadCountA), 32'h0);
        chk("t1_errOverflow", 0, 32'(errOverflow[0]), 32'h0);
        reset = 2'b00;
        tick();

        // 2: back-to-back load
        startLoad(0);
        chk("t2_inReady", 0, 32'(inReady[0]), 32'h1);
        sendWord(0, 9'h1A0, 1'b0);
        sendWord(0, 9'h0C3, 1'b0);
        sendWord(0, 9'h17F, 1'b1);
        chk("t2_settle", 0, 32'(state[0]), 32'h2);
        chk("t2_settleRst", 0, 32'(cpuReset[0]), 32'h1);
        tick();
        chk("t2_run", 0, 32'(state[0]), 32'h3);
        chk("t2_runRst", 0, 32'(cpuReset[0]), 32'h0);
        chk("t2_loadCount", 0, 32'(loadCountA), 32'd3);
        exp = '{{12'd0, 9'h1A0}, {12'd1, 9'h0C3}, {12'd2, 9'h17F}};
        checkWrites("t2_writes", 0, exp);

        // 3: gapped load after a halt
        cpuDone[0] = 1'b1; tick(); cpuDone[0] = 1'b0;
        startLoad(0);
        sendWord(0, 9'h1A0, 1'b0);
        chk("t3_gapReady", 0, 32'(inReady[0]), 32'h1);
        tick();
        sendWord(0, 9'h0C3, 1'b0);
        chk("t3_gapReady", 0, 32'(inReady[0]), 32'h1);
        tick();
        sendWord(0, 9'h17F, 1'b1);
        tick(2);
        checkWrites("t3_writes", 0, exp);

        // 4: cpuDone with loadStart in RUN, then reload from address 0
        cpuDone[0] = 1'b1; loadStart[0] = 1'b1; tick();
        cpuDone[0] = 1'b0; loadStart[0] = 1'b0;
        chk("t4_halt", 0, 32'(state[0]), 32'h4);
        chk("t4_haltRst", 0, 32'(cpuReset[0]), 32'h1);
        startLoad(0);
        sendWord(0, 9'h055, 1'b0);
        chk("t4_loadCount", 0, 32'(loadCountA), 32'd1);
        tick();
        exp = '{{12'd0, 9'h055}};
        checkWrites("t4_writes", 0, exp);
        sendWord(0, 9'h0AA, 1'b1);
        tick(2);
        wlog0.delete();

        // 5: overflow on the D=3 instance
        startLoad(1);
        exp = {};
        for (int i = 0; i < 8; i++) begin
            sendWord(1, 9'(i * 3 + 1), 1'b0);
            exp.push_back({12'(i), 9'(i * 3 + 1)});
        end
        chk("t5_idle", 1, 32'(state[1]), 32'h0);
        chk("t5_errOverflow", 1, 32'(errOverflow[1]), 32'h1);
        sendWord(1, 9'h1FF, 1'b0);
        tick();
        chk("t5_loadCount", 1, 32'(loadCountB), 32'd8);
        chk("t5_inReady", 1, 32'(inReady[1]), 32'h0);
        chk("t5_cpuReset", 1, 32'(cpuReset[1]), 32'h1);
        checkWrites("t5_writes", 1, exp);

        // 6: reset aborts a load in progress
        cpuDone[0] = 1'b1; tick(); cpuDone[0] = 1'b0;
        startLoad(0);
        sendWord(0, 9'h101, 1'b0);
        sendWord(0, 9'h102, 1'b0);
        reset[0] = 1'b1; inValid[0] = 1'b1; inData[0] = 9'h103;
        tick();
        chk("t6_state", 0, 32'(state[0]), 32'h0);
        chk("t6_wrEn", 0, 32'(wrEn[0]), 32'h0);
        chk("t6_loadCount", 0, 32'(loadCountA), 32'h0);
        reset[0] = 1'b0; inData[0] = 9'h104;
        tick(3);
        inValid[0] = 1'b0;
        tick();
        exp = '{{12'd0, 9'h101}, {12'd1, 9'h102}};
        checkWrites("t6_writes", 0, exp);

        checkOn = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
`default_nettype wire
